countdown_timer_ctrl: RTL and testbench
=======================================

# countdown_timer_ctrl

Sequencing controller for a down-counter datapath: a programmable countdown timer with start/stop/pause control, prescaled tick generation, one-shot or auto-reload modes, and a terminal-count pulse. It sits between a software- or FSM-driven control source and the counter datapath. It turns a loaded value into a timed event stream for downstream blocks such as timeouts, PWM periods and watchdogs.

## Interface
- `BIT`, 8, width of the main count and of `load_val`
- `PRE_BIT`, 4, width of the prescaler; one tick every `prescale+1` clocks

- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; samples `load_val`, `prescale`, `auto_reload`
- `stop`  in  1  one-cycle abort; highest priority
- `pause`  in  1  level; holds all counting while high in RUN
- `auto_reload`  in  1  1 = periodic, 0 = one-shot; sampled at `start`
- `load_val`  in  BIT  initial/reload count; sampled at `start`
- `prescale`  in  PRE_BIT  tick divider; sampled at `start`
- `count`  out  BIT  current main count, registered
- `busy`  out  1  high in RUN or PAUSE
- `done`  out  1  high in DONE (one-shot expired)
- `tc_pulse`  out  1  one-cycle pulse at each terminal count

## Operation
- States: IDLE, RUN, PAUSE, DONE. Encoding: 2'b00, 2'b01, 2'b10, 2'b11.
- Reset (async): state IDLE; `count`=0; prescaler=0; `tc_pulse`=0; `busy`=0; `done`=0; latched config=0.
- IDLE/DONE + `start`:
  - Latch `load_val`→`load_r`, `prescale`→`pre_r`, `auto_reload`→`ar_r`.
  - Set `count`←`load_val` and prescaler←`prescale`, then go to RUN.
- `start` with `load_val`=0: immediate expiry. On the same edge, `count`←0, `tc_pulse`←1, state←DONE, regardless of `auto_reload`.
- RUN, `pause`=0, each clock:
  - If prescaler≠0, the prescaler decrements.
  - If prescaler=0, a tick occurs: prescaler←`pre_r` and the main count steps.
- Main count step on a tick:
  - If `count`>1: `count`←`count`−1.
  - If `count`=1: `tc_pulse`←1. If `ar_r`=1: `count`←`load_r`, stay in RUN. Else: `count`←0, state←DONE.
- Auto-reload mode never shows `count`=0. The period is `load_r`×(`pre_r`+1) clocks.
- RUN + `pause`=1: go to PAUSE on that edge. No decrement on that edge for either counter.
- PAUSE: `count` and prescaler hold. `pause`=0 returns to RUN; counting resumes on the following edge.
- `stop` in any state: state←IDLE, `count`←0, prescaler←0, `tc_pulse`←0.
- Simultaneous events:
  - `stop` together with `start`: `stop` wins.
  - `start` in RUN/PAUSE: ignored.
  - `pause` in IDLE/DONE: ignored.
  - `start` and `pause` in IDLE: start wins. Enter RUN; pause takes effect on the next edge.
- Arithmetic is unsigned and modulo width. Underflow below 0 never occurs, because of the `count`=1 terminal rule.

## Timing
- All outputs are registered. Nothing is combinational from the inputs.
- Start-to-first-value latency: `count`=`load_val` is visible the cycle after the `start` edge.
- Terminal count timing, with `load_val`=N≥1 and `prescale`=P:
  - `tc_pulse` is high during the cycle after edge N×(P+1), counting the start edge as edge 0.
  - In one-shot mode, `done` rises together with `tc_pulse`.
- `tc_pulse` is exactly one cycle wide, except that back-to-back pulses occur when `load_r`=1, P=0 and auto-reload is set.
- `done` stays high until `start` or `stop`. `busy` falls on the same edge that `done` rises.
- Reset mid-operation: outputs reach reset values immediately and asynchronously. The first `start` after deassertion behaves normally.

## Structure
- Shared header/package `countdown_defs`: the state encodings and the default `BIT`/`PRE_BIT` values.
- Sub-module `ld_down_counter #(BIT)`:
  - Ports: `clk`, `reset_n`, `load`, `en`, `d`, `q`, `is_one`.
  - Behaviour: a loadable, enabled down counter with async reset.
  - Instantiated twice: once as the main counter (width `BIT`) and once as the prescaler (width `PRE_BIT`).
- The controller holds the FSM, the latched config and the `tc_pulse` register.

## Test plan
- Reset, then `start` with `load_val`=3, P=0, one-shot:
  - `count` reads 3, 2, 1, 0 on consecutive cycles.
  - `tc_pulse` and `done` rise 3 cycles after start; `busy` falls on the same edge.
- `load_val`=2, P=2, auto-reload: `tc_pulse` every 6 cycles, four times in a row; `count` cycles 2, 1, 2, 1 and never shows 0.
- One-shot, `load_val`=5, P=0:
  - Assert `pause` for 4 cycles after `count`=3; `count` holds at 3.
  - `tc_pulse` is delayed by exactly 4 cycles.
- `stop` and `start` asserted together mid-RUN: state goes to IDLE, `count`=0, `busy`=0, and no `tc_pulse`.
- `start` with `load_val`=0: `tc_pulse`=1 and `done`=1 the next cycle. A second `start` during RUN is ignored; `count` is unaffected.
- Assert `reset_n` low asynchronously mid-count with `count`=7: all outputs are 0 before the next clock edge. After release, a new `start` with `load_val`=4 counts normally.

Source files
------------

// File: rtl/countdown_timer_ctrl_pkg.sv
// countdown_defs: shared definitions for the countdown timer slice.
//   BIT_DEF     - default width of the main count / load value
//   PRE_BIT_DEF - default width of the prescaler
//   state_t     - controller state encoding
package countdown_defs;

  localparam int unsigned BIT_DEF     = 8;
  localparam int unsigned PRE_BIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// countdown_timer_ctrl_if: control/status bundle between a control source
// (master) and the countdown timer controller (slave).
//   start/stop        - one-cycle requests
//   pause             - level hold
//   auto_reload       - 1 = periodic, 0 = one-shot (sampled at start)
//   load_val/prescale - count and tick divider (sampled at start)
//   count/busy/done/tc_pulse - registered status returned by the timer
interface countdown_timer_ctrl_if #(
  parameter int unsigned BIT     = countdown_defs::BIT_DEF,
  parameter int unsigned PRE_BIT = countdown_defs::PRE_BIT_DEF
);
  logic               start;
  logic               stop;
  logic               pause;
  logic               auto_reload;
  logic [BIT-1:0]     load_val;
  logic [PRE_BIT-1:0] prescale;
  logic [BIT-1:0]     count;
  logic               busy;
  logic               done;
  logic               tc_pulse;

  modport master (
    output start, stop, pause, auto_reload, load_val, prescale,
    input  count, busy, done, tc_pulse
  );

  modport slave (
    input  start, stop, pause, auto_reload, load_val, prescale,
    output count, busy, done, tc_pulse
  );
endinterface

// File: rtl/countdown_timer_ctrl_ld_down_counter.sv
// ld_down_counter: loadable, enabled down counter with async active-low reset.
//   clk, reset_n - clock and asynchronous reset (q clears to 0)
//   load, d      - load d into q (has priority over en)
//   en           - decrement q by one
//   q            - current value
//   is_one       - q == 1
module ld_down_counter #(
  parameter int unsigned BIT = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           load,
  input  logic           en,
  input  logic [BIT-1:0] d,
  output logic [BIT-1:0] q,
  output logic           is_one
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= q - BIT'(1);
    end
  end

  assign is_one = (q == BIT'(1));

endmodule

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: sequencing controller for a prescaled down-counter.
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - slave side of countdown_timer_ctrl_if (start/stop/pause,
//             config inputs; count/busy/done/tc_pulse outputs)
// Holds the IDLE/RUN/PAUSE/DONE FSM, the configuration latched at start and
// the terminal-count pulse register; two ld_down_counter instances form the
// main count and the prescaler.
module countdown_timer_ctrl
  import countdown_defs::*;
#(
  parameter int unsigned BIT     = BIT_DEF,
  parameter int unsigned PRE_BIT = PRE_BIT_DEF
) (
  input logic                   clk,
  input logic                   reset_n,
  countdown_timer_ctrl_if.slave bus
);

  state_t             state, state_n;
  logic [BIT-1:0]     load_r;
  logic [PRE_BIT-1:0] pre_r;
  logic               ar_r;
  logic               tc_r, tc_n;
  logic               cfg_we;

  logic               cnt_load, cnt_en, cnt_one;
  logic [BIT-1:0]     cnt_d, cnt_q;
  logic               pre_load, pre_en, pre_one;
  logic [PRE_BIT-1:0] pre_d, pre_q;
  logic               tick;

  ld_down_counter #(.BIT(BIT)) u_main_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (cnt_load),
    .en     (cnt_en),
    .d      (cnt_d),
    .q      (cnt_q),
    .is_one (cnt_one)
  );

  ld_down_counter #(.BIT(PRE_BIT)) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (pre_load),
    .en     (pre_en),
    .d      (pre_d),
    .q      (pre_q),
    .is_one (pre_one)
  );

  assign tick = (pre_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      tc_r   <= 1'b0;
      load_r <= '0;
      pre_r  <= '0;
      ar_r   <= 1'b0;
    end else begin
      state <= state_n;
      tc_r  <= tc_n;
      if (cfg_we) begin
        load_r <= bus.load_val;
        pre_r  <= bus.prescale;
        ar_r   <= bus.auto_reload;
      end
    end
  end

  always_comb begin
    state_n  = state;
    tc_n     = 1'b0;
    cfg_we   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_d    = load_r;
    pre_load = 1'b0;
    pre_en   = 1'b0;
    pre_d    = pre_r;

    if (bus.stop) begin
      state_n  = ST_IDLE;
      cnt_load = 1'b1;
      cnt_d    = '0;
      pre_load = 1'b1;
      pre_d    = '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            cfg_we   = 1'b1;
            cnt_load = 1'b1;
            cnt_d    = bus.load_val;
            pre_load = 1'b1;
            pre_d    = bus.prescale;
            // A zero load expires on the start edge itself.
            if (bus.load_val == '0) begin
              state_n = ST_DONE;
              tc_n    = 1'b1;
            end else begin
              state_n = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_n = ST_PAUSE;
          end else if (!tick) begin
            pre_en = 1'b1;
          end else begin
            pre_load = 1'b1;
            if (cnt_one) begin
              tc_n = 1'b1;
              if (ar_r) begin
                cnt_load = 1'b1;
              end else begin
                // 1 -> 0 via the decrement path ends the one-shot.
                cnt_en  = 1'b1;
                state_n = ST_DONE;
              end
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (!bus.pause) begin
            state_n = ST_RUN;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // A prescaler sitting at one must reach zero on an uninterrupted RUN edge.
  a_pre_one_to_zero: assert property (@(posedge clk) disable iff (!reset_n)
    (state == ST_RUN && !bus.pause && !bus.stop && pre_one) |=> (pre_q == '0));

  assign bus.count    = cnt_q;
  assign bus.busy     = (state == ST_RUN) || (state == ST_PAUSE);
  assign bus.done     = (state == ST_DONE);
  assign bus.tc_pulse = tc_r;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl: directed self-checking bench for countdown_timer_ctrl.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_countdown_timer_ctrl;

  logic clk;
  logic reset_n;
  int unsigned n_cmp;
  int unsigned n_err;

  countdown_timer_ctrl_if bus_if ();

  countdown_timer_ctrl #(.BIT(8), .PRE_BIT(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int unsigned cnt, input int unsigned busy,
                           input int unsigned done, input int unsigned tc);
    check({tag, ".count"}, bus_if.count, cnt);
    check({tag, ".busy"}, bus_if.busy, busy);
    check({tag, ".done"}, bus_if.done, done);
    check({tag, ".tc"}, bus_if.tc_pulse, tc);
  endtask

  task automatic do_start(input int unsigned lv, input int unsigned ps, input logic ar);
    bus_if.start       = 1'b1;
    bus_if.load_val    = 8'(lv);
    bus_if.prescale    = 4'(ps);
    bus_if.auto_reload = ar;
    step();
    bus_if.start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n            = 1'b0;
    bus_if.start       = 1'b0;
    bus_if.stop        = 1'b0;
    bus_if.pause       = 1'b0;
    bus_if.auto_reload = 1'b0;
    bus_if.load_val    = '0;
    bus_if.prescale    = '0;
    #2;
    check_out("reset", 0, 0, 0, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check_out("idle", 0, 0, 0, 0);

    // One-shot, N=3, P=0: count 3,2,1,0; tc/done after edge 3.
    do_start(3, 0, 1'b0);
    check_out("os3.e0", 3, 1, 0, 0);
    step(); check_out("os3.e1", 2, 1, 0, 0);
    step(); check_out("os3.e2", 1, 1, 0, 0);
    step(); check_out("os3.e3", 0, 0, 1, 1);
    step(); check_out("os3.e4", 0, 0, 1, 0);

    // Auto-reload, N=2, P=2: tc after edges 6,12,18,24; count 2,1 per 3 edges.
    do_start(2, 2, 1'b1);
    check_out("ar.e0", 2, 1, 0, 0);
    for (int e = 1; e <= 24; e++) begin
      step();
      check($sformatf("ar.e%0d.count", e), bus_if.count, (((e / 3) % 2) == 0) ? 2 : 1);
      check($sformatf("ar.e%0d.tc", e), bus_if.tc_pulse, ((e % 6) == 0) ? 1 : 0);
      check($sformatf("ar.e%0d.busy", e), bus_if.busy, 1);
    end
    bus_if.stop = 1'b1;
    step();
    bus_if.stop = 1'b0;
    check_out("ar.stop", 0, 0, 0, 0);

    // One-shot N=5, P=0 with pause seen on edges 3..5 (entry edge and two
    // PAUSE edges) plus the exit edge 6 that does not count: tc moves from
    // edge 5 to edge 9, i.e. 4 cycles later.
    do_start(5, 0, 1'b0);
    check_out("pz.e0", 5, 1, 0, 0);
    step(); check_out("pz.e1", 4, 1, 0, 0);
    step(); check_out("pz.e2", 3, 1, 0, 0);
    bus_if.pause = 1'b1;
    step(); check_out("pz.e3", 3, 1, 0, 0);
    step(); check_out("pz.e4", 3, 1, 0, 0);
    step(); check_out("pz.e5", 3, 1, 0, 0);
    bus_if.pause = 1'b0;
    step(); check_out("pz.e6", 3, 1, 0, 0);
    step(); check_out("pz.e7", 2, 1, 0, 0);
    step(); check_out("pz.e8", 1, 1, 0, 0);
    step(); check_out("pz.e9", 0, 0, 1, 1);

    // stop + start together mid-RUN: stop wins, no tc afterwards.
    do_start(6, 0, 1'b0);
    check_out("ss.e0", 6, 1, 0, 0);
    step(); check_out("ss.e1", 5, 1, 0, 0);
    bus_if.stop  = 1'b1;
    bus_if.start = 1'b1;
    step();
    bus_if.stop  = 1'b0;
    bus_if.start = 1'b0;
    check_out("ss.e2", 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(); check_out($sformatf("ss.idle%0d", i), 0, 0, 0, 0);
    end

    // Zero load: immediate expiry.
    do_start(0, 3, 1'b1);
    check_out("z.e0", 0, 0, 1, 1);
    step(); check_out("z.e1", 0, 0, 1, 0);

    // Second start during RUN (N=4, P=1) is ignored.
    do_start(4, 1, 1'b0);
    check_out("rs.e0", 4, 1, 0, 0);
    bus_if.start    = 1'b1;
    bus_if.load_val = 8'd9;
    step();
    bus_if.start = 1'b0;
    check_out("rs.e1", 4, 1, 0, 0);
    step(); check_out("rs.e2", 3, 1, 0, 0);
    bus_if.stop = 1'b1;
    step();
    bus_if.stop = 1'b0;
    check_out("rs.stop", 0, 0, 0, 0);

    // Async reset mid-count at count=7, then normal restart with N=4.
    do_start(9, 0, 1'b0);
    step();
    step(); check_out("rst.pre", 7, 1, 0, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check_out("rst.async", 0, 0, 0, 0);
    step();
    check_out("rst.held", 0, 0, 0, 0);
    reset_n = 1'b1;
    step();
    do_start(4, 0, 1'b0);
    check_out("rst.e0", 4, 1, 0, 0);
    step(); check_out("rst.e1", 3, 1, 0, 0);
    step(); check_out("rst.e2", 2, 1, 0, 0);
    step(); check_out("rst.e3", 1, 1, 0, 0);
    step(); check_out("rst.e4", 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
